// File: rtl/ifetch_responder_if.sv
// Memory-side bus of the instruction fetch responder: one read request, one response.
// The responder is the master and drives mem_ren/mem_addr.
interface ifetch_responder_if;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output mem_ren,
    output mem_addr,
    input  mem_busy,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_ren,
    input  mem_addr,
    output mem_busy,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/ifetch_responder.sv
// Fetch responder between the PC and instruction memory: IDLE/REQ/WAIT/RESP FSM.
// Optional one-entry fetch buffer is enabled by defining IFETCH_BUF_EN.
module ifetch_responder #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                PCaddr,
  input  logic                       cpu_en,
  input  logic                       buf_flush,
  output logic [31:0]                instr,
  output logic                       iready,
  output logic                       fetch_err,
  ifetch_responder_if.master         mem,
  output logic [1:0]                 o_dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_instr, w_instr_nxt;
  logic          r_err, w_err_nxt;
  logic          w_hit;
  logic [31:0]   w_buf_instr;

`ifdef IFETCH_BUF_EN
  logic        r_buf_vld;
  logic [31:0] r_buf_addr;
  logic [31:0] r_buf_instr;

  // A flush in the same cycle suppresses the hit as well as any fill.
  assign w_hit       = r_buf_vld && !buf_flush && (PCaddr == r_buf_addr);
  assign w_buf_instr = r_buf_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_vld <= 1'b0;
    end else if (buf_flush) begin
      r_buf_vld <= 1'b0;
    end else if (r_state == S_RESP && !r_err) begin
      r_buf_vld   <= 1'b1;
      r_buf_addr  <= r_addr;
      r_buf_instr <= r_instr;
    end
  end
`else
  logic w_unused_flush;
  assign w_unused_flush = buf_flush;
  assign w_hit          = 1'b0;
  assign w_buf_instr    = NOP_INSTR;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_cnt   <= '0;
      r_instr <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_instr <= w_instr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = r_instr;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (cpu_en) begin
          w_addr_nxt = PCaddr;
          if (PCaddr[1:0] != 2'b00) begin
            w_instr_nxt = NOP_INSTR;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end else if (w_hit) begin
            w_instr_nxt = w_buf_instr;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (!mem.mem_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // rvalid takes precedence over the timeout on the same cycle.
        if (mem.mem_rvalid) begin
          w_instr_nxt = mem.mem_rdata;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_instr_nxt = NOP_INSTR;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign instr        = r_instr;
  assign iready       = (r_state == S_RESP);
  assign fetch_err    = (r_state == S_RESP) && r_err;
  assign mem.mem_ren  = (r_state == S_REQ);
  assign mem.mem_addr = r_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: stimulus pushes expected {fetch_err, instr}
// into a queue, a negedge monitor pops and compares on every iready pulse.
module tb_ifetch_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCaddr;
  logic        cpu_en;
  logic        buf_flush;
  logic [31:0] instr;
  logic        iready;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  ifetch_responder_if mem_bus ();

  always #5 clk = ~clk;

  ifetch_responder #(.TIMEOUT_CYCLES(4), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCaddr      (PCaddr),
    .cpu_en      (cpu_en),
    .buf_flush   (buf_flush),
    .instr       (instr),
    .iready      (iready),
    .fetch_err   (fetch_err),
    .mem         (mem_bus),
    .o_dbg_state (dbg_state)
  );

  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every iready pulse must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (iready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_iready: got err=%0b instr=0x%08h, expected no response", fetch_err, instr);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({fetch_err, instr} !== mon_exp) begin
              n_fail++;
              $display("FAIL response: got err=%0b instr=0x%08h, expected err=%0b instr=0x%08h",
                       fetch_err, instr, mon_exp[32], mon_exp[31:0]);
            end
          end
        end else if (fetch_err !== 1'b0) begin
          n_fail++;
          $display("FAIL err_without_iready: got fetch_err=%0b, expected 0", fetch_err);
        end
      end
    end
  end

  // One fetch with a simple memory model: busy_n busy cycles in REQ, rvalid on the
  // rv_dly-th WAIT cycle (0 = never). Latency counts cycles from the IDLE cycle to RESP.
  task automatic fetch(input logic [31:0] addr, input int busy_n, input int rv_dly,
                       input logic [31:0] rdata, input logic exp_err, input logic [31:0] exp_instr,
                       input int exp_lat, input int exp_ren, input string tag);
    int   k, ren_n, busy_left, wait_cnt;
    logic acc, addr_bad, done;
    exp_q.push_back({exp_err, exp_instr});
    PCaddr = addr;
    cpu_en = 1'b1;
    mem_bus.mem_busy   = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    k = 1; ren_n = 0; busy_left = busy_n; wait_cnt = 0;
    acc = 1'b0; addr_bad = 1'b0; done = 1'b0;
    while (!done && k < 300) begin
      step();
      k++;
      cpu_en = 1'b0;
      PCaddr = 32'hdead_bee0 ^ 32'(k);
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'hbad0_bad0;
      if (acc) begin
        wait_cnt = rv_dly;
        acc = 1'b0;
      end
      if (wait_cnt == 1) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = rdata;
      end
      if (wait_cnt > 0) wait_cnt--;
      if (iready) begin
        done = 1'b1;
        mem_bus.mem_busy = 1'b0;
      end else if (mem_bus.mem_ren) begin
        ren_n++;
        if (mem_bus.mem_addr !== addr) addr_bad = 1'b1;
        if (busy_left > 0) begin
          mem_bus.mem_busy = 1'b1;
          busy_left--;
        end else begin
          mem_bus.mem_busy = 1'b0;
          acc = 1'b1;
        end
      end else begin
        mem_bus.mem_busy = 1'b0;
      end
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_no_iready: got no iready in %0d cycles, expected latency %0d", tag, k, exp_lat);
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_ren_cycles"}, 32'(ren_n), 32'(exp_ren));
    check({tag, "_addr_bad"}, 32'(addr_bad), 32'd0);
    mem_bus.mem_rvalid = 1'b0;
    step();
    check({tag, "_iready_pulse"}, 32'(iready), 32'd0);
    check({tag, "_instr_held"}, instr, exp_instr);
  endtask

  initial begin
    rst       = 1'b1;
    cpu_en    = 1'b0;
    PCaddr    = 32'd0;
    buf_flush = 1'b0;
    mem_bus.mem_busy   = 1'b0;
    mem_bus.mem_rdata  = 32'd0;
    mem_bus.mem_rvalid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_instr", instr, 32'd0);
    check("rst_iready", 32'(iready), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_mem_ren", 32'(mem_bus.mem_ren), 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    fetch(32'h0000_0000, 0, 1, 32'h0050_0093, 1'b0, 32'h0050_0093, 4, 1, "basic");
    fetch(32'h0000_0104, 3, 1, 32'h00a0_0113, 1'b0, 32'h00a0_0113, 7, 4, "busy");
    fetch(32'h0000_0006, 0, 1, 32'h1111_1111, 1'b1, NOP,           2, 0, "misalign");
    fetch(32'h0000_0040, 0, 2, 32'h00c0_0193, 1'b0, 32'h00c0_0193, 5, 1, "wait1");
    fetch(32'h0000_0044, 0, 4, 32'h00d0_0213, 1'b0, 32'h00d0_0213, 7, 1, "rv_on_timeout");
    fetch(32'h0000_0200, 0, 0, 32'h2222_2222, 1'b1, NOP,           7, 1, "timeout");

    // Late rvalid while idle must be ignored.
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h1234_5678;
    step();
    mem_bus.mem_rvalid = 1'b0;
    step();
    check("late_rv_iready", 32'(iready), 32'd0);
    check("late_rv_instr", instr, NOP);

    // Reset in WAIT abandons the fetch; a following rvalid is ignored.
    PCaddr = 32'h0000_0020;
    cpu_en = 1'b1;
    step();
    cpu_en = 1'b0;
    check("rstw_mem_ren", 32'(mem_bus.mem_ren), 32'd1);
    step();
    check("rstw_state_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h0bad_f00d;
    check("rstw_instr", instr, 32'd0);
    check("rstw_iready", 32'(iready), 32'd0);
    check("rstw_mem_ren", 32'(mem_bus.mem_ren), 32'd0);
    check("rstw_mem_addr", mem_bus.mem_addr, 32'd0);
    step();
    mem_bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_iready", 32'(iready), 32'd0);
      step();
    end
    fetch(32'h0000_0008, 0, 1, 32'h0030_0313, 1'b0, 32'h0030_0313, 4, 1, "after_rst");

`ifdef IFETCH_BUF_EN
    fetch(32'h0000_0010, 0, 1, 32'h0070_0393, 1'b0, 32'h0070_0393, 4, 1, "buf_fill");
    fetch(32'h0000_0010, 0, 1, 32'h3333_3333, 1'b0, 32'h0070_0393, 2, 0, "buf_hit");
    buf_flush = 1'b1;
    step();
    buf_flush = 1'b0;
    fetch(32'h0000_0010, 0, 1, 32'h0080_0413, 1'b0, 32'h0080_0413, 4, 1, "buf_flushed");
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL pending_responses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
